connect4_board_ctrl: RTL and testbench
======================================

// Module: connect4_board_ctrl
// PURPOSE
// - Parametrised Connect-4 game engine: holds the board, accepts drops and alternates players.
// - Detects a WIN_LEN-in-a-row win or a full-board draw, then drives active-low green/blue LED grids.
// - Sits between the debounced button/column-select logic and the LED matrix scan driver.
// PARAMETERS
// COLS      7   playable columns; COLS <= DISP
// ROWS      6   playable rows; ROWS <= DISP-1 (display row 0 is reserved for the cursor)
// DISP      8   display grid dimension (DISP x DISP)
// WIN_LEN   4   tokens in a line needed to win; 2 <= WIN_LEN <= min(ROWS,COLS)
// BLINK_DIV 2**22  cycles per blink half-period in the WIN state
// PORTS
// clock           in   1    system clock, all state on rising edge
// rst_n           in   1    asynchronous active-low reset
// select          in   1    one-cycle drop request pulse (already debounced)
// column_position in   $clog2(DISP)   cursor column, 0 = leftmost
// green_grid      out  [DISP-1:0][DISP-1:0]  player 0 LEDs, 0 = lit
// blue_grid       out  [DISP-1:0][DISP-1:0]  player 1 LEDs, 0 = lit
// turn            out  1    player to move (0 = green, 1 = blue)
// drop_accepted   out  1    one-cycle pulse: the drop was legal and written
// column_full     out  1    comb: the cursor column is full or out of range
// game_over       out  1    state is WIN or DRAW
// winner          out  2    00 none, 01 green, 10 blue, 11 draw
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=PLAY, turn=0; all heights and cells cleared.
//   - Every grid bit=1; drop_accepted=0, game_over=0, winner=00.
// - Board storage:
//   - Two ROWS x COLS occupancy planes, one per player.
//   - Per-column height counter of width $clog2(ROWS+1), saturating at ROWS.
// - FSM states PLAY -> CHECK -> {PLAY | WIN | DRAW}; WIN and DRAW are left only by reset.
// - PLAY:
//   - A select with column_position < COLS and height < ROWS is accepted:
//     - Set cell (height,col) in the plane of `turn`.
//     - Increment height, record the last move (row,col).
//     - Pulse drop_accepted on the next cycle; go to CHECK.
//   - A select on a full or out-of-range column is ignored: no state change, no pulse, turn kept.
// - CHECK (exactly 1 cycle):
//   - From the last move, count consecutive same-player cells along 4 axes: horizontal, vertical, both diagonals.
//   - Count both directions, up to WIN_LEN-1 each side; ignore out-of-board indices.
//   - If any axis total (including the placed cell) >= WIN_LEN: WIN, winner = turn+1 (01 or 10), turn frozen.
//   - Else if the total drop count == ROWS*COLS: DRAW, winner=11.
//   - Else toggle turn and return to PLAY.
//   - Win is checked before draw: a last move that fills the board and wins reports WIN.
// - select is ignored in CHECK, WIN and DRAW.
// - Latency: select at edge N -> cell visible on the grids and drop_accepted at N+1 -> turn/winner update at N+2.
// - Display mapping (registered, 1-cycle lag from state):
//   - Cell (r,c), with r=0 at the bottom -> grid[DISP-1-r][DISP-1-c] = 0 in the owner's grid.
//   - Unused rows/columns stay 1.
//   - Row 0 in PLAY/CHECK: bit DISP-1-column_position = 0 in the `turn` grid only; other grid row 0 all 1.
//   - Row 0 when column_position >= COLS: all 1 in both grids.
//   - Row 0 in WIN: winner grid row 0 alternates all-0/all-1 every BLINK_DIV cycles via a free counter cleared on WIN entry.
//   - Row 0 in DRAW: both grids row 0 = all 0.
// - column_full is combinational from the heights and column_position; valid in any state.
// - Reset asserted mid-game or mid-CHECK clears everything immediately; no partial move survives.
// TESTING
// - Reset, then select at col 0 -> green_grid[7][7]=0 at N+1, drop_accepted pulse, turn=1 at N+2.
// - Six drops in col 3, then a 7th -> column_full=1, 7th ignored: no pulse, turn unchanged, height 6.
// - Green at cols 0,1,2,3 alternating with blue at col 6 -> after the 7th drop winner=01, game_over=1, further select ignored.
// - Blue builds a rising diagonal (0,0)-(3,3) -> winner=10; blue row 0 blinks at BLINK_DIV (set 4 in sim).
// - Fill the board in a no-win pattern (42 drops) -> winner=11, both row-0s all 0.
// - Assert rst_n low mid-CHECK -> all outputs at reset values asynchronously; select after release behaves as the first move.

Source files
------------

// File: rtl/connect4_board_ctrl_if.sv
// Player-facing bundle of the Connect-4 engine: drop requests in, board LEDs and game status out.
interface connect4_board_ctrl_if #(
  parameter int DISP = 8
);
  localparam int CPW = $clog2(DISP);

  logic                       select;
  logic [CPW-1:0]             column_position;
  logic [DISP-1:0][DISP-1:0]  green_grid;
  logic [DISP-1:0][DISP-1:0]  blue_grid;
  logic                       turn;
  logic                       drop_accepted;
  logic                       column_full;
  logic                       game_over;
  logic [1:0]                 winner;

  modport master (
    output select, column_position,
    input  green_grid, blue_grid, turn, drop_accepted, column_full, game_over, winner
  );

  modport slave (
    input  select, column_position,
    output green_grid, blue_grid, turn, drop_accepted, column_full, game_over, winner
  );
endinterface

// File: rtl/connect4_board_ctrl.sv
// Connect-4 engine: stores both players' tokens, alternates turns, detects win/draw
// and renders the board plus a cursor row onto two active-low LED grids.
module connect4_board_ctrl #(
  parameter int COLS      = 7,
  parameter int ROWS      = 6,
  parameter int DISP      = 8,
  parameter int WIN_LEN   = 4,
  parameter int BLINK_DIV = 2**22
) (
  input  logic                  clock,
  input  logic                  rst_n,
  connect4_board_ctrl_if.slave  bus
);

  localparam int CPW = $clog2(DISP);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int HW  = $clog2(ROWS + 1);
  localparam int DW  = $clog2(ROWS * COLS + 1);
  localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [HW-1:0]  FULL_HEIGHT = HW'(ROWS);
  localparam logic [DW-1:0]  FULL_COUNT  = DW'(ROWS * COLS);
  localparam logic [BW-1:0]  BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [CPW-1:0] LAST_BIT    = CPW'(DISP - 1);

  typedef enum logic [1:0] {ST_PLAY, ST_CHECK, ST_WIN, ST_DRAW} state_e;
  typedef logic [ROWS-1:0][COLS-1:0] plane_t;
  typedef logic [DISP-1:0][DISP-1:0] grid_t;

  state_e                 state_q, state_d;
  plane_t                 plane_g_q, plane_g_d;
  plane_t                 plane_b_q, plane_b_d;
  logic [COLS-1:0][HW-1:0] height_q, height_d;
  logic [RW-1:0]          last_row_q, last_row_d;
  logic [CW-1:0]          last_col_q, last_col_d;
  logic                   turn_q, turn_d;
  logic [1:0]             winner_q, winner_d;
  logic [DW-1:0]          drop_cnt_q, drop_cnt_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   blink_q, blink_d;

  logic                   drop_accepted_q, drop_accepted_d;
  logic                   turn_out_q, turn_out_d;
  logic [1:0]             winner_out_q, winner_out_d;
  logic                   game_over_q, game_over_d;
  grid_t                  green_q, green_d;
  grid_t                  blue_q, blue_d;

  logic                   col_in_range;
  logic [CW-1:0]          col_idx;
  logic [HW-1:0]          col_height;
  logic                   column_full;
  plane_t                 cur_plane;
  int                     axis_h, axis_v, axis_d, axis_a;
  logic                   win;

  // Same-player run length stepping away from (r0,c0); off-board cells end the run.
  function automatic int run_len(input plane_t p, input int r0, input int c0,
                                 input int dr, input int dc);
    int   n;
    int   r;
    int   c;
    logic alive;
    n     = 0;
    alive = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      r = r0 + k * dr;
      c = c0 + k * dc;
      if (alive && r >= 0 && r < ROWS && c >= 0 && c < COLS && p[r[RW-1:0]][c[CW-1:0]])
        n++;
      else
        alive = 1'b0;
    end
    return n;
  endfunction

  always_comb begin
    col_in_range = int'(bus.column_position) < COLS;
    col_idx      = bus.column_position[CW-1:0];
    col_height   = col_in_range ? height_q[col_idx] : FULL_HEIGHT;
    column_full  = !col_in_range || (col_height == FULL_HEIGHT);
  end

  always_comb begin
    cur_plane = turn_q ? plane_b_q : plane_g_q;
    axis_h = 1 + run_len(cur_plane, int'(last_row_q), int'(last_col_q), 0, 1)
               + run_len(cur_plane, int'(last_row_q), int'(last_col_q), 0, -1);
    axis_v = 1 + run_len(cur_plane, int'(last_row_q), int'(last_col_q), 1, 0)
               + run_len(cur_plane, int'(last_row_q), int'(last_col_q), -1, 0);
    axis_d = 1 + run_len(cur_plane, int'(last_row_q), int'(last_col_q), 1, 1)
               + run_len(cur_plane, int'(last_row_q), int'(last_col_q), -1, -1);
    axis_a = 1 + run_len(cur_plane, int'(last_row_q), int'(last_col_q), 1, -1)
               + run_len(cur_plane, int'(last_row_q), int'(last_col_q), -1, 1);
    win = (axis_h >= WIN_LEN) || (axis_v >= WIN_LEN) ||
          (axis_d >= WIN_LEN) || (axis_a >= WIN_LEN);
  end

  // NOTE: every *_d starts as its *_q so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    plane_g_d   = plane_g_q;
    plane_b_d   = plane_b_q;
    height_d    = height_q;
    last_row_d  = last_row_q;
    last_col_d  = last_col_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    drop_cnt_d  = drop_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    unique case (state_q)
      ST_PLAY: begin
        if (bus.select && !column_full) begin
          if (turn_q) plane_b_d[col_height[RW-1:0]][col_idx] = 1'b1;
          else        plane_g_d[col_height[RW-1:0]][col_idx] = 1'b1;
          height_d[col_idx] = col_height + HW'(1);
          last_row_d        = col_height[RW-1:0];
          last_col_d        = col_idx;
          drop_cnt_d        = drop_cnt_q + DW'(1);
          state_d           = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Win has priority so a board-filling winning move is reported as a win.
        if (win) begin
          state_d     = ST_WIN;
          winner_d    = turn_q ? 2'b10 : 2'b01;
          blink_cnt_d = '0;
          blink_d     = 1'b0;
        end else if (drop_cnt_q == FULL_COUNT) begin
          state_d  = ST_DRAW;
          winner_d = 2'b11;
        end else begin
          turn_d  = !turn_q;
          state_d = ST_PLAY;
        end
      end
      ST_WIN: begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_d     = !blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
      ST_DRAW: ;
      default: state_d = ST_PLAY;
    endcase
  end

  // Board rows occupy grid rows DISP-1 downwards; grid row 0 is the cursor/status row.
  always_comb begin
    green_d = '1;
    blue_d  = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (plane_g_q[r][c]) green_d[DISP-1-r][DISP-1-c] = 1'b0;
        if (plane_b_q[r][c]) blue_d[DISP-1-r][DISP-1-c]  = 1'b0;
      end
    end
    unique case (state_q)
      ST_PLAY, ST_CHECK: begin
        if (col_in_range) begin
          if (turn_q) blue_d[0][LAST_BIT - bus.column_position]  = 1'b0;
          else        green_d[0][LAST_BIT - bus.column_position] = 1'b0;
        end
      end
      ST_WIN: begin
        if (winner_q == 2'b10) blue_d[0]  = {DISP{blink_q}};
        else                   green_d[0] = {DISP{blink_q}};
      end
      ST_DRAW: begin
        green_d[0] = '0;
        blue_d[0]  = '0;
      end
      default: ;
    endcase

    drop_accepted_d = (state_q == ST_CHECK);
    turn_out_d      = turn_q;
    winner_out_d    = winner_q;
    game_over_d     = (state_q == ST_WIN) || (state_q == ST_DRAW);
  end

  // NOTE: the board planes are plain flops and must be cleared by reset so no partial game survives.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_PLAY;
      plane_g_q       <= '0;
      plane_b_q       <= '0;
      height_q        <= '0;
      last_row_q      <= '0;
      last_col_q      <= '0;
      turn_q          <= 1'b0;
      winner_q        <= 2'b00;
      drop_cnt_q      <= '0;
      blink_cnt_q     <= '0;
      blink_q         <= 1'b0;
      drop_accepted_q <= 1'b0;
      turn_out_q      <= 1'b0;
      winner_out_q    <= 2'b00;
      game_over_q     <= 1'b0;
      green_q         <= '1;
      blue_q          <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      plane_g_q       <= plane_g_d;
      plane_b_q       <= plane_b_d;
      height_q        <= height_d;
      last_row_q      <= last_row_d;
      last_col_q      <= last_col_d;
      turn_q          <= turn_d;
      winner_q        <= winner_d;
      drop_cnt_q      <= drop_cnt_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_q         <= blink_d;
      drop_accepted_q <= drop_accepted_d;
      turn_out_q      <= turn_out_d;
      winner_out_q    <= winner_out_d;
      game_over_q     <= game_over_d;
      green_q         <= green_d;
      blue_q          <= blue_d;
    end
  end

  assign bus.green_grid    = green_q;
  assign bus.blue_grid     = blue_q;
  assign bus.turn          = turn_out_q;
  assign bus.drop_accepted = drop_accepted_q;
  assign bus.column_full   = column_full;
  assign bus.game_over     = game_over_q;
  assign bus.winner        = winner_out_q;

endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Directed bench for connect4_board_ctrl: accepted drops queue their expected cell,
// a monitor matches each drop_accepted pulse against the queue and the LED grids.
module tb_connect4_board_ctrl;

  localparam int COLS      = 7;
  localparam int ROWS      = 6;
  localparam int DISP      = 8;
  localparam int WIN_LEN   = 4;
  localparam int BLINK_DIV = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  connect4_board_ctrl_if #(.DISP(DISP)) bus ();

  connect4_board_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DISP(DISP), .WIN_LEN(WIN_LEN), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int row;
    int col;
    bit player;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   m_h[COLS];
  bit   m_turn;
  bit   m_over;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    logic gbit;
    logic bbit;
    if (rst_n && bus.drop_accepted) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", bus.drop_accepted, 1'b0);
      end else begin
        e    = sb.pop_front();
        gbit = bus.green_grid[DISP-1-e.row][DISP-1-e.col];
        bbit = bus.blue_grid[DISP-1-e.row][DISP-1-e.col];
        check("cell_owner_lit", e.player ? bbit : gbit, 1'b0);
        check("cell_other_dark", e.player ? gbit : bbit, 1'b1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    rst_n      = 1'b0;
    bus.select = 1'b0;
    sb.delete();
    foreach (m_h[i]) m_h[i] = 0;
    m_turn = 1'b0;
    m_over = 1'b0;
    #1;
    check("rst_green", bus.green_grid, '1);
    check("rst_blue", bus.blue_grid, '1);
    check("rst_turn", bus.turn, 1'b0);
    check("rst_winner", bus.winner, 2'b00);
    check("rst_game_over", bus.game_over, 1'b0);
    check("rst_pulse", bus.drop_accepted, 1'b0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Returns at the negedge after edge N+2, when turn/winner reflect the drop.
  task automatic drop(input int col, input bit ends);
    bit   acc;
    exp_t e;
    acc = !m_over && col < COLS && m_h[col] < ROWS;
    @(negedge clock);
    bus.column_position = col[2:0];
    bus.select          = 1'b1;
    if (acc) begin
      e.row    = m_h[col];
      e.col    = col;
      e.player = m_turn;
      sb.push_back(e);
      m_h[col]++;
      if (ends) m_over = 1'b1;
      else      m_turn = !m_turn;
    end
    @(negedge clock);
    bus.select = 1'b0;
    repeat (2) @(negedge clock);
    check("turn", bus.turn, m_turn);
    check("game_over", bus.game_over, m_over);
    check("pulse_done", bus.drop_accepted, 1'b0);
    check("pulse_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.select          = 1'b0;
    bus.column_position = '0;

    // First move and cursor hand-over
    do_reset();
    check("cursor_green_start", bus.green_grid[0], 8'h7F);
    check("cursor_blue_start", bus.blue_grid[0], 8'hFF);
    drop(0, 1'b0);
    check("first_cell_row", bus.green_grid[7], 8'h7F);
    check("cursor_green_after", bus.green_grid[0], 8'hFF);
    check("cursor_blue_after", bus.blue_grid[0], 8'h7F);

    // Column fill and out-of-range cursor
    do_reset();
    for (int i = 0; i < 6; i++) drop(3, 1'b0);
    check("col3_full", bus.column_full, 1'b1);
    drop(3, 1'b0);
    check("col3_green_stack",
          {bus.green_grid[7][4], bus.green_grid[6][4], bus.green_grid[5][4],
           bus.green_grid[4][4], bus.green_grid[3][4], bus.green_grid[2][4]}, 6'b010101);
    check("col3_blue_stack",
          {bus.blue_grid[7][4], bus.blue_grid[6][4], bus.blue_grid[5][4],
           bus.blue_grid[4][4], bus.blue_grid[3][4], bus.blue_grid[2][4]}, 6'b101010);
    check("col3_no_overflow", bus.green_grid[1] & bus.blue_grid[1], 8'hFF);
    bus.column_position = 3'd4;
    #1;
    check("col4_not_full", bus.column_full, 1'b0);
    bus.column_position = 3'd7;
    repeat (2) @(negedge clock);
    check("col7_full", bus.column_full, 1'b1);
    check("col7_cursor_green", bus.green_grid[0], 8'hFF);
    check("col7_cursor_blue", bus.blue_grid[0], 8'hFF);
    drop(7, 1'b0);

    // Green horizontal win
    do_reset();
    drop(0, 1'b0); drop(6, 1'b0); drop(1, 1'b0); drop(6, 1'b0);
    drop(2, 1'b0); drop(6, 1'b0); drop(3, 1'b1);
    check("hwin_winner", bus.winner, 2'b01);
    drop(4, 1'b0);
    check("hwin_winner_held", bus.winner, 2'b01);
    check("hwin_ignored_cell", bus.green_grid[7][3] & bus.blue_grid[7][3], 1'b1);

    // Blue rising diagonal win and blink
    do_reset();
    drop(1, 1'b0); drop(0, 1'b0); drop(2, 1'b0); drop(1, 1'b0); drop(3, 1'b0);
    drop(3, 1'b0); drop(2, 1'b0); drop(2, 1'b0); drop(3, 1'b0); drop(3, 1'b1);
    check("dwin_winner", bus.winner, 2'b10);
    for (int i = 0; i < 8; i++) begin
      check("dwin_blink_blue", bus.blue_grid[0], (i < 4) ? 8'h00 : 8'hFF);
      check("dwin_blink_green", bus.green_grid[0], 8'hFF);
      @(negedge clock);
    end

    // Full board without a line: draw
    do_reset();
    for (int j = 0; j < 3; j++) begin drop(0, 1'b0); drop(2, 1'b0); drop(2, 1'b0); drop(0, 1'b0); end
    for (int j = 0; j < 3; j++) begin drop(1, 1'b0); drop(3, 1'b0); drop(3, 1'b0); drop(1, 1'b0); end
    for (int j = 0; j < 3; j++) begin drop(4, 1'b0); drop(6, 1'b0); drop(6, 1'b0); drop(4, 1'b0); end
    for (int j = 0; j < 5; j++) drop(5, 1'b0);
    drop(5, 1'b1);
    check("draw_winner", bus.winner, 2'b11);
    check("draw_row0_green", bus.green_grid[0], 8'h00);
    check("draw_row0_blue", bus.blue_grid[0], 8'h00);
    check("draw_bottom_green", bus.green_grid[7], 8'h33);
    check("draw_bottom_blue", bus.blue_grid[7], 8'hCD);
    check("draw_row1_green", bus.green_grid[6], 8'hCD);
    check("draw_row1_blue", bus.blue_grid[6], 8'h33);
    check("draw_unused_row", bus.green_grid[1] & bus.blue_grid[1], 8'hFF);

    // Reset while the engine is in its check cycle
    do_reset();
    bus.column_position = 3'd2;
    @(negedge clock);
    bus.select = 1'b1;
    @(negedge clock);
    bus.select = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("midchk_green", bus.green_grid, '1);
    check("midchk_blue", bus.blue_grid, '1);
    check("midchk_turn", bus.turn, 1'b0);
    check("midchk_pulse", bus.drop_accepted, 1'b0);
    check("midchk_column_full", bus.column_full, 1'b0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    drop(2, 1'b0);
    check("post_rst_row0", bus.green_grid[7], 8'hDF);
    check("post_rst_row1", bus.green_grid[6], 8'hFF);
    check("post_rst_blue", bus.blue_grid[7], 8'hFF);

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
